axils_wr_ch: RTL
================

AXILS_WR_CH -- requirements
Module: axils_wr_ch

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 32'h0000_0000, meaning the base of the decoded write window.
REQ-002 SHALL have parameter ADDR_SIZE, default 32'h0000_1000, meaning the window size in bytes (power of two).
REQ-003 SHALL have the following ports (name, direction, width, meaning):
- ACLK  in  1  clock, all logic on rising edge.
- ARESETn  in  1  asynchronous, active-low reset.
- AWADDR  in  32  write address.
- AWPROT  in  3  protection; accepted, ignored.
- AWVALID  in  1  address valid.
- AWREADY  out  1  address ready.
- WDATA  in  32  write data.
- WSTRB  in  4  byte strobes.
- WVALID  in  1  data valid.
- WREADY  out  1  data ready.
- BVALID  out  1  response valid.
- BREADY  in  1  response ready.
- BRESP  out  2  response code.
- reg_wen  out  1  local write request, held until acknowledged.
- reg_addr  out  32  captured AWADDR.
- reg_wdata  out  32  captured WDATA.
- reg_wstb  out  4  captured WSTRB.
- reg_wack  in  1  local write complete.
- reg_werr  in  1  local error; sampled with reg_wack.

Function
REQ-004 SHALL implement states IDLE, DATA_WAIT, ADDR_WAIT, LOCAL_WR and RESP.
REQ-005 IDLE SHALL drive AWREADY=1 and WREADY=1; both are registered outputs.
REQ-006 In IDLE, AW and W handshakes in the same cycle SHALL capture both and go to LOCAL_WR, with AWREADY=WREADY=0 from the next cycle.
REQ-007 In IDLE, an AW-only handshake SHALL capture the address and go to DATA_WAIT (AWREADY=0, WREADY=1); a W-only handshake SHALL capture the data and strobes and go to ADDR_WAIT (WREADY=0, AWREADY=1).
REQ-008 DATA_WAIT and ADDR_WAIT SHALL capture the missing beat on its handshake, drop the remaining ready, and go to LOCAL_WR.
REQ-009 LOCAL_WR SHALL assert reg_wen, with reg_addr/reg_wdata/reg_wstb stable, from the first cycle in the state until the cycle reg_wack=1 is sampled. reg_wen SHALL be low the following cycle.
REQ-010 On reg_wack, the block SHALL go to RESP and assert BVALID the next cycle. BRESP SHALL be 2'b10 (SLVERR) if reg_werr=1, else 2'b00 (OKAY).
REQ-011 RESP SHALL hold BVALID and BRESP stable until BVALID&BREADY. The next cycle SHALL have BVALID=0, AWREADY=1, WREADY=1 and state IDLE.
REQ-012 Minimum transaction latency: AW+W handshake at cycle N, reg_wen at N+1, reg_wack at N+1, BVALID at N+2.
REQ-013 WSTRB=4'b0000 SHALL still perform a local write, with reg_wstb=0.
REQ-014 At most one transaction SHALL be outstanding; no new AW/W is accepted between capture and B handshake.
REQ-015 reg_wack while not in LOCAL_WR SHALL be ignored.

Reset
REQ-016 ARESETn low SHALL immediately force state=IDLE and drive AWREADY=0, WREADY=0, BVALID=0, BRESP=2'b00, reg_wen=0, reg_addr=0, reg_wdata=0, reg_wstb=0.
REQ-017 AWREADY and WREADY SHALL rise on the first ACLK edge after ARESETn deasserts.
REQ-018 Reset during LOCAL_WR or RESP SHALL discard the transaction; no BVALID SHALL follow.

Configuration
REQ-019 With AXILS_WR_DECERR_EN defined, a captured AWADDR outside [ADDR_BASE, ADDR_BASE+ADDR_SIZE) SHALL skip LOCAL_WR (reg_wen never asserted) and enter RESP with BRESP=2'b11 (DECERR) one cycle after the last capture.
REQ-020 Without AXILS_WR_DECERR_EN, every address SHALL be forwarded, and there SHALL be no comparator logic.

Structure
REQ-021 Shared package axil_pkg SHALL hold the BRESP enum (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3) and this block's state enum.
REQ-022 The block SHALL be a single module with no sub-module; the decode comparator stays inline.

Verification
REQ-023 The bench SHALL cover at least these scenarios:
- AW 0x10 and W 0xDEADBEEF/0xF at cycle N, reg_wack at N+1, BREADY=1 -> reg_wen at N+1, BVALID with OKAY at N+2.
- W first at N, AW 0x20 at N+3 -> WREADY=0 from N+1, AWREADY=1 until N+3, reg_addr=0x20 with earlier data.
- reg_wack delayed 5 cycles with reg_werr=1 -> reg_wen high for 6 cycles, then BRESP=SLVERR.
- BREADY held low 4 cycles -> BVALID/BRESP stable; AWVALID offered meanwhile is not accepted.
- DECERR_EN, AW 0x2000, window 0x0/0x1000 -> no reg_wen, BRESP=DECERR; without the macro -> reg_wen with reg_addr=0x2000.
- ARESETn pulsed low during RESP -> BVALID=0 at once, readies return one cycle after release.

Source files
------------

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes, bus widths, write-channel FSM states.
package axil_pkg;

    localparam int unsigned AXIL_ADDR_W = 32;
    localparam int unsigned AXIL_DATA_W = 32;
    localparam int unsigned AXIL_STRB_W = AXIL_DATA_W / 8;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } axi_resp_e;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DATA_WAIT = 3'd1,
        ADDR_WAIT = 3'd2,
        LOCAL_WR  = 3'd3,
        RESP      = 3'd4
    } wr_state_e;

endpackage

// File: rtl/axils_wr_ch.sv
// AXI4-Lite slave write channel: joins AW and W beats, forwards one local
// register write at a time, and returns the B response.
// Optional: define AXILS_WR_DECERR_EN to answer out-of-window addresses with
// DECERR without issuing a local write.
module axils_wr_ch
    import axil_pkg::*;
#(
    parameter logic [AXIL_ADDR_W-1:0] ADDR_BASE = 32'h0000_0000,
    parameter logic [AXIL_ADDR_W-1:0] ADDR_SIZE = 32'h0000_1000
) (
    input  logic                   ACLK,
    input  logic                   ARESETn,
    input  logic [AXIL_ADDR_W-1:0] AWADDR,
    input  logic [2:0]             AWPROT,
    input  logic                   AWVALID,
    output logic                   AWREADY,
    input  logic [AXIL_DATA_W-1:0] WDATA,
    input  logic [AXIL_STRB_W-1:0] WSTRB,
    input  logic                   WVALID,
    output logic                   WREADY,
    output logic                   BVALID,
    input  logic                   BREADY,
    output logic [1:0]             BRESP,
    output logic                   reg_wen,
    output logic [AXIL_ADDR_W-1:0] reg_addr,
    output logic [AXIL_DATA_W-1:0] reg_wdata,
    output logic [AXIL_STRB_W-1:0] reg_wstb,
    input  logic                   reg_wack,
    input  logic                   reg_werr
);

    // Window must be a non-empty power of two with a size-aligned base.
    if ((ADDR_SIZE == 32'd0) || ((ADDR_SIZE & (ADDR_SIZE - 32'd1)) != 32'd0)
        || ((ADDR_BASE & (ADDR_SIZE - 32'd1)) != 32'd0)) begin : g_bad_window
        $error("axils_wr_ch: ADDR_SIZE must be a power of two and ADDR_BASE aligned to it");
    end

    wr_state_e                state_q, state_d;
    axi_resp_e                bresp_q, bresp_d;
    logic                     awready_d, wready_d, bvalid_d, reg_wen_d;
    logic [AXIL_ADDR_W-1:0]   addr_d;
    logic [AXIL_DATA_W-1:0]   wdata_d;
    logic [AXIL_STRB_W-1:0]   wstb_d;
    logic                     aw_hs, w_hs, last_cap;
`ifdef AXILS_WR_DECERR_EN
    logic                     in_window;
`endif

    // Protection bits carry no meaning for this slave.
    logic unused_awprot;
    assign unused_awprot = ^AWPROT;

    assign aw_hs = AWVALID & AWREADY;
    assign w_hs  = WVALID & WREADY;
    assign BRESP = bresp_q;

    // State and all outputs are registered; reset drops every ready and valid.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            bresp_q   <= OKAY;
            AWREADY   <= 1'b0;
            WREADY    <= 1'b0;
            BVALID    <= 1'b0;
            reg_wen   <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_wstb  <= '0;
        end else begin
            state_q   <= state_d;
            bresp_q   <= bresp_d;
            AWREADY   <= awready_d;
            WREADY    <= wready_d;
            BVALID    <= bvalid_d;
            reg_wen   <= reg_wen_d;
            reg_addr  <= addr_d;
            reg_wdata <= wdata_d;
            reg_wstb  <= wstb_d;
        end
    end

    // Next state, beat capture and next values of the registered outputs.
    always_comb begin
        state_d  = state_q;
        bresp_d  = bresp_q;
        addr_d   = reg_addr;
        wdata_d  = reg_wdata;
        wstb_d   = reg_wstb;
        last_cap = 1'b0;

        if (aw_hs) begin
            addr_d = AWADDR;
        end
        if (w_hs) begin
            wdata_d = WDATA;
            wstb_d  = WSTRB;
        end

        unique case (state_q)
            IDLE: begin
                if (aw_hs && w_hs) last_cap = 1'b1;
                else if (aw_hs)    state_d = DATA_WAIT;
                else if (w_hs)     state_d = ADDR_WAIT;
            end
            DATA_WAIT: if (w_hs)  last_cap = 1'b1;
            ADDR_WAIT: if (aw_hs) last_cap = 1'b1;
            LOCAL_WR: begin
                if (reg_wack) begin
                    state_d = RESP;
                    bresp_d = reg_werr ? SLVERR : OKAY;
                end
            end
            RESP: if (BVALID && BREADY) state_d = IDLE;
            default: state_d = IDLE;
        endcase

`ifdef AXILS_WR_DECERR_EN
        in_window = (addr_d >= ADDR_BASE) && (32'(addr_d - ADDR_BASE) < ADDR_SIZE);
        if (last_cap) begin
            if (in_window) begin
                state_d = LOCAL_WR;
            end else begin
                state_d = RESP;
                bresp_d = DECERR;
            end
        end
`else
        if (last_cap) state_d = LOCAL_WR;
`endif

        awready_d = (state_d == IDLE) || (state_d == ADDR_WAIT);
        wready_d  = (state_d == IDLE) || (state_d == DATA_WAIT);
        reg_wen_d = (state_d == LOCAL_WR);
        bvalid_d  = (state_d == RESP);
    end

endmodule
